// File: rtl/ksa_shuffle_ctrl.sv
// RC4 key-scheduling shuffle sequencer: owns the S RAM port and swaps s[i]/s[j] for i=0..255.
// Optional build macro KSA_SKIP_SELF_SWAP_EN skips the read/write sequence when j lands on i.
module ksa_shuffle_ctrl #(
    parameter int unsigned KEY_BYTES  = 3,
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             s_q,
    output logic [7:0]             s_address,
    output logic [7:0]             s_data,
    output logic                   s_wren,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        StIdle,
        StRdI,
        StWaitI,
        StRdJ,
        StWaitJ,
        StWrI,
        StWrJ,
        StDone
    } state_e;

    localparam logic [1:0] WaitLast = 2'(MEM_RD_LAT - 1);

    state_e      state_q, state_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [7:0]  si_q, si_d;
    logic [7:0]  sj_q, sj_d;
    logic [1:0]  wait_q, wait_d;
    logic [7:0]  key_byte;
    logic [7:0]  jn;
    logic        last_wait;
    int unsigned key_idx;

    // Key byte 0 is the most significant byte of secret_key.
    always_comb begin
        key_byte = '0;
        key_idx  = 32'(i_q) % KEY_BYTES;
        for (int unsigned k = 0; k < KEY_BYTES; k++) begin
            if (key_idx == k) key_byte = secret_key[8*(KEY_BYTES-1-k) +: 8];
        end
    end

    assign jn        = j_q + s_q + key_byte;
    assign last_wait = (wait_q == WaitLast);

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        wait_d    = wait_q;
        s_address = '0;
        s_data    = '0;
        s_wren    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = StRdI;
                end
            end
            StRdI: begin
                busy      = 1'b1;
                s_address = i_q;
                wait_d    = '0;
                state_d   = StWaitI;
            end
            StWaitI: begin
                busy      = 1'b1;
                s_address = i_q;
                if (last_wait) begin
                    si_d    = s_q;
                    j_d     = jn;
                    state_d = StRdJ;
`ifdef KSA_SKIP_SELF_SWAP_EN
                    // Swapping s[i] with itself is a no-op, so move straight on.
                    if (jn == i_q) begin
                        if (i_q == 8'hff) begin
                            state_d = StDone;
                        end else begin
                            i_d     = i_q + 8'd1;
                            state_d = StRdI;
                        end
                    end
`endif
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            StRdJ: begin
                busy      = 1'b1;
                s_address = j_q;
                wait_d    = '0;
                state_d   = StWaitJ;
            end
            StWaitJ: begin
                busy      = 1'b1;
                s_address = j_q;
                if (last_wait) begin
                    sj_d    = s_q;
                    state_d = StWrI;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            StWrI: begin
                busy      = 1'b1;
                s_address = i_q;
                s_data    = sj_q;
                s_wren    = 1'b1;
                state_d   = StWrJ;
            end
            StWrJ: begin
                busy      = 1'b1;
                s_address = j_q;
                s_data    = si_q;
                s_wren    = 1'b1;
                if (i_q == 8'hff) begin
                    state_d = StDone;
                end else begin
                    i_d     = i_q + 8'd1;
                    state_d = StRdI;
                end
            end
            StDone: begin
                done = 1'b1;
                if (!start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_ksa_shuffle_ctrl.sv
// Directed bench for ksa_shuffle_ctrl: 1-cycle and 2-cycle RAM models, software KSA reference.
module tb_ksa_shuffle_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, start2, fill;
    logic [23:0] key;

    logic [7:0]  q1, addr1, data1;
    logic        wren1, busy1, done1;
    logic [7:0]  q2a, q2b, addr2, data2;
    logic        wren2, busy2, done2;

    logic [7:0]  mem1 [256];
    logic [7:0]  mem2 [256];
    logic [7:0]  exp_s [256];
    int          wr1 = 0;
    int          wr2 = 0;
    int          exp_writes, exp_done;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fill) begin
            for (int k = 0; k < 256; k++) mem1[k] <= 8'(k);
        end else if (wren1) begin
            mem1[addr1] <= data1;
        end
        q1 <= mem1[addr1];
        if (wren1) wr1 <= wr1 + 1;
    end

    always @(posedge clk) begin
        if (fill) begin
            for (int k = 0; k < 256; k++) mem2[k] <= 8'(k);
        end else if (wren2) begin
            mem2[addr2] <= data2;
        end
        q2a <= mem2[addr2];
        q2b <= q2a;
        if (wren2) wr2 <= wr2 + 1;
    end

    ksa_shuffle_ctrl #(.KEY_BYTES(3), .MEM_RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .secret_key(key), .s_q(q1),
        .s_address(addr1), .s_data(data1), .s_wren(wren1), .busy(busy1), .done(done1)
    );

    ksa_shuffle_ctrl #(.KEY_BYTES(3), .MEM_RD_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .secret_key(key), .s_q(q2b),
        .s_address(addr2), .s_data(data2), .s_wren(wren2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference KSA; also derives write count and done cycle for the given read latency.
    task automatic model(input logic [23:0] k_in, input int lat);
        int         j;
        logic [7:0] kb, t;
        logic       skip;
        for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
        j          = 0;
        exp_writes = 0;
        exp_done   = 1;
        for (int i = 0; i < 256; i++) begin
            kb = 8'(k_in >> (8 * (2 - (i % 3))));
            j  = (j + int'(exp_s[i]) + int'(kb)) % 256;
`ifdef KSA_SKIP_SELF_SWAP_EN
            skip = (j == i);
`else
            skip = 1'b0;
`endif
            t        = exp_s[i];
            exp_s[i] = exp_s[j];
            exp_s[j] = t;
            if (skip) begin
                exp_done += 1 + lat;
            end else begin
                exp_done   += 4 + 2 * lat;
                exp_writes += 2;
            end
        end
    endtask

    task automatic fill_s();
        @(negedge clk) fill = 1'b1;
        @(negedge clk) fill = 1'b0;
    endtask

    // Leaves the bench at the negedge of cycle 1 (first RD_I).
    task automatic go(input int which);
        @(negedge clk);
        if (which == 1) start2 = 1'b1;
        else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int n0, output int n);
        n = n0;
        while (!((which == 1) ? done2 : done1) && n < 10000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_mem(input int which, input string tag);
        int mm = 0;
        for (int k = 0; k < 256; k++) begin
            if (((which == 1) ? mem2[k] : mem1[k]) !== exp_s[k]) mm++;
        end
        check(tag, mm, 0);
    endtask

    initial begin
        int n, w0, off, cnt0;
        reset  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        fill   = 1'b0;
        key    = 24'h000249;
        repeat (3) @(negedge clk);
        check("rst_addr", addr1, 0);
        check("rst_data", data1, 0);
        check("rst_wren", wren1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_busy2", busy2, 0);
        reset = 1'b0;

        // Key 0x000249: i=0 self-swaps (j=0), i=1 gives j=0+1+2=3 -> s[1]=3, s[3]=1.
        model(key, 1);
        fill_s();
        w0 = wr1;
        go(0);
        check("s1_busy", busy1, 1);
`ifdef KSA_SKIP_SELF_SWAP_EN
        off = 6;
`else
        off = 10;
`endif
        repeat (off) @(negedge clk);
        check("s1_it1_wri_wren", wren1, 1);
        check("s1_it1_wri_addr", addr1, 1);
        check("s1_it1_wri_data", data1, 3);
        @(negedge clk);
        check("s1_it1_wrj_addr", addr1, 3);
        check("s1_it1_wrj_data", data1, 1);
        wait_done(0, off + 2, n);
        check("s1_done_cycle", n, exp_done);
`ifndef KSA_SKIP_SELF_SWAP_EN
        check("s1_done_cycle_abs", n, 1537);
        check("s1_writes_abs", wr1 - w0, 512);
`endif
        check("s1_writes", wr1 - w0, exp_writes);
        check_mem(0, "s1_final_s");

        // Key 0: iteration 0 has jn=0=i.
        key = 24'h000000;
        model(key, 1);
        fill_s();
        w0   = wr1;
        go(0);
        cnt0 = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (wren1 && addr1 == 8'd0 && data1 == 8'd0) cnt0++;
        end
`ifdef KSA_SKIP_SELF_SWAP_EN
        check("s2_addr0_writes", cnt0, 0);
`else
        check("s2_addr0_writes", cnt0, 2);
`endif
        wait_done(0, 6, n);
        check("s2_done_cycle", n, exp_done);
        check("s2_writes", wr1 - w0, exp_writes);
        check_mem(0, "s2_final_s");

        // start toggled while busy must be ignored.
        key = 24'h000249;
        model(key, 1);
        fill_s();
        w0 = wr1;
        go(0);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = (c % 2 == 1);
        end
        start = 1'b0;
        wait_done(0, 201, n);
        check("s5_done_cycle", n, exp_done);
        check("s5_writes", wr1 - w0, exp_writes);
        check_mem(0, "s5_final_s");

        // Reset in WAIT_J of iteration 100 (cycle 604), then a clean rerun.
        fill_s();
        w0 = wr1;
        go(0);
        repeat (603) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("s3_rst_wren", wren1, 0);
        check("s3_rst_busy", busy1, 0);
        check("s3_rst_done", done1, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("s3_idle_busy", busy1, 0);
        check("s3_idle_wren", wren1, 0);
`ifndef KSA_SKIP_SELF_SWAP_EN
        check("s3_partial_writes", wr1 - w0, 200);
`endif
        fill_s();
        w0 = wr1;
        go(0);
        wait_done(0, 1, n);
        check("s3_done_cycle", n, exp_done);
        check("s3_writes", wr1 - w0, exp_writes);
        check_mem(0, "s3_final_s");

        // start held through completion.
        fill_s();
        w0 = wr1;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        wait_done(0, 1, n);
        check("s4_done_cycle", n, exp_done);
        repeat (20) @(negedge clk);
        check("s4_done_held", done1, 1);
        check("s4_busy_held", busy1, 0);
        check("s4_no_rerun", wr1 - w0, exp_writes);
        check_mem(0, "s4_final_s");
        start = 1'b0;
        @(negedge clk);
        check("s4_done_drop", done1, 0);
        start = 1'b1;
        @(negedge clk);
        check("s4_restart_busy", busy1, 1);
        start = 1'b0;
        wait_done(0, 1, n);
        check("s4_pass2_done", done1, 1);
        @(negedge clk);

        // Two-cycle RAM latency.
        model(key, 2);
        fill_s();
        w0 = wr2;
        go(1);
        wait_done(1, 1, n);
        check("s6_done_cycle", n, exp_done);
`ifndef KSA_SKIP_SELF_SWAP_EN
        check("s6_done_cycle_abs", n, 2049);
`endif
        check("s6_writes", wr2 - w0, exp_writes);
        check_mem(1, "s6_final_s");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
